mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sequences the single shared multi-cycle main memory between the I-cache and D-cache.
//  - Serves I-cache and D-cache block-fill misses, and D-cache write-through stores.
//  - Steers returning words into the owning cache's data array and signals fill completion.
//  - Sits between both cache controllers and the memory; the cpu stalls on the busy/done handshake.
// PARAMETERS
//  ADDR_W       16  byte-address width
//  DATA_W       16  memory word width
//  BLOCK_WORDS  8   words per cache block (power of 2); block = 2*BLOCK_WORDS bytes
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous active-low reset
//  i_miss_req    in   1       I-cache miss; held until i_fill_done
//  i_miss_addr   in   ADDR_W  I-miss byte address
//  d_miss_req    in   1       D-cache miss; held until d_fill_done
//  d_miss_addr   in   ADDR_W  D-miss byte address
//  d_wr_req      in   1       D write-through; held until d_wr_done
//  d_wr_addr     in   ADDR_W  store byte address
//  d_wr_data     in   DATA_W  store data
//  mem_data_out  in   DATA_W  read data from memory
//  mem_valid     in   1       mem_data_out valid (pipelined memory, in-order returns)
//  mem_enable    out  1       memory access this cycle
//  mem_wr        out  1       1=write, 0=read (qualified by mem_enable)
//  mem_addr      out  ADDR_W  memory byte address
//  mem_data_in   out  DATA_W  write data to memory
//  fill_we       out  1       write fill_data into owner's data array
//  fill_sel      out  1       owner of fill: 0=I, 1=D
//  fill_word     out  log2(BLOCK_WORDS)  word index in block
//  fill_data     out  DATA_W  = mem_data_out
//  fill_base     out  ADDR_W  block base address of current fill (for tag write)
//  i_fill_done   out  1       1-cycle pulse with last I word
//  d_fill_done   out  1       1-cycle pulse with last D word
//  d_wr_done     out  1       1-cycle pulse in store cycle
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE; all counters 0; every output 0.
//  - FSM states: IDLE, WRITE, FILL; owner register sets fill_sel.
//  - IDLE arbitration (fixed priority): d_wr_req > d_miss_req > i_miss_req.
//    - Grant transfers on the next edge.
//    - No grant while in WRITE/FILL; losing requesters wait.
//  - WRITE (exactly 1 cycle): mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data.
//    - d_wr_done=1 in the same cycle; returns to IDLE.
//  - FILL grant: latch base = addr & ~(2*BLOCK_WORDS-1); fill_base=base throughout.
//    - Issue: cycles 1..BLOCK_WORDS after grant assert mem_enable=1, mem_wr=0, mem_addr=base+2*issue_cnt.
//    - Receive: each mem_valid asserts fill_we, fill_word=recv_cnt, then recv_cnt++.
//    - Done: on the valid for word BLOCK_WORDS-1, pulse {i|d}_fill_done, then go to IDLE.
//    - Completion depends only on mem_valid, never on fixed latency.
//    - Address arithmetic is modulo 2^ADDR_W; the base is aligned, so no carry out of block.
//  - Boundary conditions:
//    - Requester drops mid-fill: the fill still completes and done still pulses (no abort).
//    - mem_valid in IDLE or WRITE is ignored (no fill_we).
//    - Reset mid-operation: immediate IDLE and counters cleared; the next fill restarts at word 0.
//    - Back-to-back: the IDLE cycle after done re-arbitrates; minimum 1 IDLE cycle between grants.
//    - Request addresses are sampled only at grant; later changes are ignored.
// STRUCTURE
//  - mem_arb_defs.vh (shared include):
//    - state encodings ST_IDLE/ST_WRITE/ST_FILL.
//    - OWN_I=0, OWN_D=1.
//    - block offset mask.
//  - Sub-module fill_counter: log2(BLOCK_WORDS)+1-bit counter with clear/inc/terminal flag.
//    - Instantiated twice: issue_cnt and recv_cnt.
//  - FSM, arbitration and output muxing stay in mem_arbiter.
// TESTING (bench memory model: 4-cycle pipelined read latency)
//  1. Single I miss at 0x1236 in cycle 0.
//     -> mem_addr 0x1230..0x123E in cycles 1-8.
//     -> fill_we, fill_sel=0, words 0..7 in cycles 5-12.
//     -> i_fill_done in cycle 12; IDLE in cycle 13.
//  2. I miss 0x0040 and D miss 0x2000 together.
//     -> D fill first (fill_sel=1, base 0x2000).
//     -> I fill issue begins 2 cycles after d_fill_done.
//  3. d_wr_req 0x0100/0xA5A5 with I miss in cycle 0.
//     -> cycle 1: mem_wr=1, mem_addr=0x0100, d_wr_done=1.
//     -> I fill issues from cycle 3.
//  4. rst_n low after 3 fill words.
//     -> all outputs 0 immediately.
//     -> stale mem_valid gives no fill_we.
//     -> a new miss restarts at word 0.
//  5. i_miss_req dropped in fill cycle 4 -> all 8 words written; i_fill_done still pulses.
//  6. D miss at 0xFFFE -> base 0xFFF0; addresses 0xFFF0..0xFFFE; no wrap beyond 0xFFFE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM state codes, fill owner codes
// and the block-size helper used to derive the block offset mask.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Bytes per cache block; a memory word is two bytes.
  function automatic int unsigned blk_bytes(input int unsigned block_words);
    return 2 * block_words;
  endfunction

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// Word counter for block fills: synchronous clear has priority over increment.
// Single-cycle update; term_o flags cnt_o == TERM combinationally.
module mem_arbiter_fill_counter #(
  parameter int unsigned CW   = 4,
  parameter int unsigned TERM = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          term_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == CW'(TERM));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pipelined memory between I/D block fills and D write-through stores.
// Grant one edge after request in IDLE; losers stall on busy until a later IDLE cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_miss_req,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  input  logic                           d_miss_req,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  input  logic                           d_wr_req,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [DATA_W-1:0]              d_wr_data,
  input  logic [DATA_W-1:0]              mem_data_out,
  input  logic                           mem_valid,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_data_in,
  output logic                           fill_we,
  output logic                           fill_sel,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [DATA_W-1:0]              fill_data,
  output logic [ADDR_W-1:0]              fill_base,
  output logic                           i_fill_done,
  output logic                           d_fill_done,
  output logic                           d_wr_done,
  output logic                           busy
);

  localparam int unsigned WW = $clog2(BLOCK_WORDS);
  localparam int unsigned CW = WW + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(blk_bytes(BLOCK_WORDS) - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic          is_idle, is_write, is_fill;
  logic          cnt_clr, issue_go, fill_last;
  logic [CW-1:0] issue_cnt, recv_cnt;
  logic          issue_term, recv_term;

  assign is_idle  = (state_q == ST_IDLE);
  assign is_write = (state_q == ST_WRITE);
  assign is_fill  = (state_q == ST_FILL);

  // Counters sit cleared in IDLE so every fill starts at word 0.
  assign cnt_clr   = is_idle;
  assign issue_go  = is_fill & ~issue_term;
  assign fill_we   = is_fill & mem_valid & ~recv_cnt[CW-1];
  assign fill_last = fill_we & recv_term;

  mem_arbiter_fill_counter #(
    .CW  (CW),
    .TERM(BLOCK_WORDS)
  ) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (issue_go),
    .cnt_o (issue_cnt),
    .term_o(issue_term)
  );

  mem_arbiter_fill_counter #(
    .CW  (CW),
    .TERM(BLOCK_WORDS - 1)
  ) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (fill_we),
    .cnt_o (recv_cnt),
    .term_o(recv_term)
  );

  // Fixed priority: store > D miss > I miss. Addresses are captured only here.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    base_d    = base_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (d_wr_req) begin
          state_d   = ST_WRITE;
          wr_addr_d = d_wr_addr;
          wr_data_d = d_wr_data;
        end else if (d_miss_req) begin
          state_d = ST_FILL;
          owner_d = OWN_D;
          base_d  = d_miss_addr & ~BLK_MASK;
        end else if (i_miss_req) begin
          state_d = ST_FILL;
          owner_d = OWN_I;
          base_d  = i_miss_addr & ~BLK_MASK;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_FILL: begin
        if (fill_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      base_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      base_q    <= base_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    mem_addr = '0;
    if (is_write) begin
      mem_addr = wr_addr_q;
    end else if (issue_go) begin
      mem_addr = base_q + ADDR_W'({issue_cnt, 1'b0});
    end
  end

  // Fill-side outputs are held at zero outside their qualifying cycles.
  assign mem_enable  = is_write | issue_go;
  assign mem_wr      = is_write;
  assign mem_data_in = is_write ? wr_data_q : '0;
  assign fill_sel    = is_fill & (owner_q == OWN_D);
  assign fill_word   = fill_we ? recv_cnt[WW-1:0] : '0;
  assign fill_data   = fill_we ? mem_data_out : '0;
  assign fill_base   = is_fill ? base_q : '0;
  assign i_fill_done = fill_last & (owner_q == OWN_I);
  assign d_fill_done = fill_last & (owner_q == OWN_D);
  assign d_wr_done   = is_write;
  assign busy        = ~is_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: 4-cycle pipelined memory model, event logs checked
// against a transaction-level schedule built from the arbitration rules.
module tb_mem_arbiter;

  localparam int LAT = 4;

  typedef struct { int c; logic [15:0] a; logic [15:0] d; logic wr; } mev_t;
  typedef struct { int c; logic sel; logic [2:0] w; logic [15:0] d; logic [15:0] b; } fev_t;
  typedef struct { int c; int k; } dev_t;
  typedef struct { int due; logic [15:0] d; } pend_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss_req = 1'b0, d_miss_req = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic [15:0] mem_data_out = '0;
  logic        mem_valid = 1'b0;
  logic        mem_enable, mem_wr, fill_we, fill_sel;
  logic [15:0] mem_addr, mem_data_in, fill_data, fill_base;
  logic [2:0]  fill_word;
  logic        i_fill_done, d_fill_done, d_wr_done, busy;
  logic [74:0] outs;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_data_out(mem_data_out), .mem_valid(mem_valid),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word), .fill_data(fill_data),
    .fill_base(fill_base), .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_done(d_wr_done), .busy(busy)
  );

  assign outs = {mem_enable, mem_wr, mem_addr, mem_data_in, fill_we, fill_sel, fill_word,
                 fill_data, fill_base, i_fill_done, d_fill_done, d_wr_done, busy};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  logic [15:0] mem_arr [0:32767];
  logic [15:0] ref_mem [0:32767];
  pend_t pend_q[$];
  mev_t  mem_log[$], exp_mem[$];
  fev_t  fill_log[$], exp_fill[$];
  dev_t  done_log[$], exp_done[$];
  int    busy_cnt = 0, exp_busy = 0;
  int    inj_cyc = -1;
  bit    i_done_seen, d_done_seen, w_done_seen;

  // Monitor and memory request side, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (busy) busy_cnt++;
    if (mem_enable) begin
      mem_log.push_back('{cyc, mem_addr, mem_data_in, mem_wr});
      if (mem_wr) mem_arr[mem_addr[15:1]] = mem_data_in;
      else pend_q.push_back('{cyc + LAT, mem_arr[mem_addr[15:1]]});
    end
    if (fill_we) fill_log.push_back('{cyc, fill_sel, fill_word, fill_data, fill_base});
    if (i_fill_done) begin done_log.push_back('{cyc, 0}); i_done_seen = 1'b1; end
    if (d_fill_done) begin done_log.push_back('{cyc, 1}); d_done_seen = 1'b1; end
    if (d_wr_done)   begin done_log.push_back('{cyc, 2}); w_done_seen = 1'b1; end
  end

  // Memory return side: in-order returns, plus optional spurious valid.
  initial forever begin
    @(posedge clk);
    #2;
    mem_valid    = 1'b0;
    mem_data_out = '0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      mem_valid    = 1'b1;
      mem_data_out = pend_q.pop_front().d;
    end else if (inj_cyc == cyc) begin
      mem_valid    = 1'b1;
      mem_data_out = 16'hDEAD;
    end
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference schedule: all requests present at relative cycle 0, served one at a
  // time in priority order, each grant following an IDLE cycle.
  task automatic add_fill(input logic sel, input logic [15:0] addr, input int t);
    logic [15:0] base, a;
    base = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      exp_mem.push_back('{t + k, a, 16'h0, 1'b0});
      exp_fill.push_back('{t + LAT + k, sel, 3'(k), ref_mem[a[15:1]], base});
    end
    exp_done.push_back('{t + LAT + 7, int'(sel)});
    exp_busy += LAT + 8;
  endtask

  task automatic build_expected(input bit w, input bit dm, input bit im,
                                input logic [15:0] wa, input logic [15:0] wd,
                                input logic [15:0] da, input logic [15:0] ia,
                                output int gd, output int gi, output int len);
    int t = 1;
    exp_mem.delete(); exp_fill.delete(); exp_done.delete();
    exp_busy = 0; gd = -1; gi = -1;
    if (w) begin
      exp_mem.push_back('{t, wa, wd, 1'b1});
      exp_done.push_back('{t, 2});
      ref_mem[wa[15:1]] = wd;
      exp_busy += 1;
      t += 2;
    end
    if (dm) begin add_fill(1'b1, da, t); gd = t; t += LAT + 9; end
    if (im) begin add_fill(1'b0, ia, t); gi = t; t += LAT + 9; end
    len = t + 3;
  endtask

  task automatic compare_logs(input string tag, input int t0);
    check($sformatf("%s n_mem", tag), mem_log.size(), exp_mem.size());
    for (int i = 0; i < exp_mem.size() && i < mem_log.size(); i++) begin
      check($sformatf("%s mem%0d cyc", tag, i), mem_log[i].c - t0, exp_mem[i].c);
      check($sformatf("%s mem%0d addr", tag, i), mem_log[i].a, exp_mem[i].a);
      check($sformatf("%s mem%0d wr", tag, i), mem_log[i].wr, exp_mem[i].wr);
      if (exp_mem[i].wr) check($sformatf("%s mem%0d wdata", tag, i), mem_log[i].d, exp_mem[i].d);
    end
    check($sformatf("%s n_fill", tag), fill_log.size(), exp_fill.size());
    for (int i = 0; i < exp_fill.size() && i < fill_log.size(); i++) begin
      check($sformatf("%s fill%0d cyc", tag, i), fill_log[i].c - t0, exp_fill[i].c);
      check($sformatf("%s fill%0d sel", tag, i), fill_log[i].sel, exp_fill[i].sel);
      check($sformatf("%s fill%0d word", tag, i), fill_log[i].w, exp_fill[i].w);
      check($sformatf("%s fill%0d data", tag, i), fill_log[i].d, exp_fill[i].d);
      check($sformatf("%s fill%0d base", tag, i), fill_log[i].b, exp_fill[i].b);
    end
    check($sformatf("%s n_done", tag), done_log.size(), exp_done.size());
    for (int i = 0; i < exp_done.size() && i < done_log.size(); i++) begin
      check($sformatf("%s done%0d cyc", tag, i), done_log[i].c - t0, exp_done[i].c);
      check($sformatf("%s done%0d kind", tag, i), done_log[i].k, exp_done[i].k);
    end
    check($sformatf("%s busy_cycles", tag), busy_cnt, exp_busy);
  endtask

  task automatic clear_logs();
    mem_log.delete(); fill_log.delete(); done_log.delete();
    busy_cnt = 0;
    i_done_seen = 1'b0; d_done_seen = 1'b0; w_done_seen = 1'b0;
  endtask

  task automatic run_case(input string tag, input bit w, input bit dm, input bit im,
                          input logic [15:0] wa, input logic [15:0] wd,
                          input logic [15:0] da, input logic [15:0] ia,
                          input bit drop_i);
    int gd, gi, len, t0;
    build_expected(w, dm, im, wa, wd, da, ia, gd, gi, len);
    clear_logs();
    @(posedge clk);
    #1;
    t0 = cyc;
    // Spurious valid: in the WRITE cycle when a store leads, otherwise in IDLE cycle 0.
    inj_cyc = w ? t0 + 1 : t0;
    d_wr_req = w;   d_wr_addr = wa;   d_wr_data = wd;
    d_miss_req = dm; d_miss_addr = da;
    i_miss_req = im; i_miss_addr = ia;
    for (int r = 1; r < len; r++) begin
      @(posedge clk);
      #1;
      if (w_done_seen) d_wr_req = 1'b0;
      if (d_done_seen) d_miss_req = 1'b0;
      if (i_done_seen) i_miss_req = 1'b0;
      if (r == gd) d_miss_addr = 16'($urandom);
      if (r == gi) i_miss_addr = 16'($urandom);
      if (drop_i && gi >= 0 && r == gi + 3) i_miss_req = 1'b0;
    end
    compare_logs(tag, t0);
    d_wr_req = 1'b0; d_miss_req = 1'b0; i_miss_req = 1'b0;
    inj_cyc = -1;
  endtask

  initial begin
    logic [15:0] wa, wd, da, ia;
    int mask, waited;
    for (int i = 0; i < 32768; i++) begin
      mem_arr[i] = 16'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset outputs", outs, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("post-reset idle outputs", outs, '0);

    run_case("t1 imiss 1236", 0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h1236, 0);
    run_case("t2 d+i miss", 0, 1, 1, 16'h0, 16'h0, 16'h2000, 16'h0040, 0);
    run_case("t3 wr+imiss", 1, 0, 1, 16'h0100, 16'hA5A5, 16'h0, 16'($urandom), 0);

    // Reset in the middle of a fill, after three words have landed.
    clear_logs();
    @(posedge clk);
    #1 i_miss_req = 1'b1; i_miss_addr = 16'h3456;
    waited = 0;
    while (fill_log.size() < 3 && waited < 40) begin
      @(posedge clk);
      #1 waited++;
    end
    check("t4 words before reset", fill_log.size(), 3);
    rst_n = 1'b0;
    i_miss_req = 1'b0;
    #2 check("t4 outputs in reset", outs, '0);
    fill_log.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int r = 0; r < 10; r++) @(posedge clk);
    #1;
    check("t4 stale valid fill_we count", fill_log.size(), 0);
    check("t4 busy after reset", busy, 1'b0);
    run_case("t4 restart", 0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h3456, 0);

    run_case("t5 drop imiss", 0, 0, 1, 16'h0, 16'h0, 16'h0, 16'($urandom), 1);
    run_case("t6 dmiss fffe", 0, 1, 0, 16'h0, 16'h0, 16'hFFFE, 16'h0, 0);

    for (int n = 0; n < 10; n++) begin
      mask = $urandom_range(1, 7);
      da = 16'($urandom);
      ia = 16'($urandom);
      wd = 16'($urandom);
      wa = ($urandom_range(0, 1) == 1) ? ((da & 16'hFFF0) | 16'h0004) : 16'($urandom);
      run_case($sformatf("rnd%0d m%0d", n, mask), mask[2], mask[1], mask[0], wa, wd, da, ia,
               bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
